// File: rtl/multibroadcaster_tx.sv
// Serial frame transmitter: start bit, 4-bit port/line address, then MSB-first payload,
// with one-hot port enable and line-select code presented to the broadcaster during payload.
module multibroadcaster_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_port,
    input  logic [1:0]        in_line,
    input  logic [DATA_W-1:0] in_data,
    output logic              serOut,
    output logic [0:3]        PB,
    output logic [1:0]        LB,
    output logic              done,
    output logic [7:0]        frames_sent
);

    localparam int CNT_MAX = (DATA_W > 4) ? DATA_W : 4;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int SH_W    = DATA_W + 4;

    typedef enum logic [2:0] {IDLE, START, ADDR, DATA, DONE} state_t;

    state_t            state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [SH_W-1:0]   sh, shNext;
    logic [1:0]        portReg, portNext;
    logic [1:0]        lineReg, lineNext;
    logic              serNext, doneNext;
    logic [0:3]        pbNext, dataPb;
    logic [1:0]        lbNext, dataLb;
    logic [7:0]        framesNext;
    logic              accept;

    assign in_ready = (state == IDLE) && rst;
    assign accept   = in_valid && in_ready;
    assign dataPb   = 4'b1000 >> portReg;
    assign dataLb   = ~lineReg;

    // Address and payload share one shift register so serOut always takes its MSB.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        shNext     = sh;
        portNext   = portReg;
        lineNext   = lineReg;
        serNext    = 1'b1;
        pbNext     = '0;
        lbNext     = '0;
        doneNext   = 1'b0;
        framesNext = frames_sent;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = START;
                    cntNext   = '0;
                    shNext    = {in_port, in_line, in_data};
                    portNext  = in_port;
                    lineNext  = in_line;
                    serNext   = 1'b0;
                end
            end
            START: begin
                stateNext = ADDR;
                cntNext   = '0;
                serNext   = sh[SH_W-1];
                shNext    = sh << 1;
            end
            ADDR: begin
                serNext = sh[SH_W-1];
                shNext  = sh << 1;
                if (cnt == CNT_W'(3)) begin
                    stateNext = DATA;
                    cntNext   = '0;
                    pbNext    = dataPb;
                    lbNext    = dataLb;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    stateNext  = DONE;
                    cntNext    = '0;
                    doneNext   = 1'b1;
                    framesNext = frames_sent + 8'd1;
                end else begin
                    cntNext = cnt + 1'b1;
                    serNext = sh[SH_W-1];
                    shNext  = sh << 1;
                    pbNext  = dataPb;
                    lbNext  = dataLb;
                end
            end
            DONE: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sh          <= '0;
            portReg     <= '0;
            lineReg     <= '0;
            serOut      <= 1'b1;
            PB          <= '0;
            LB          <= '0;
            done        <= 1'b0;
            frames_sent <= '0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            sh          <= shNext;
            portReg     <= portNext;
            lineReg     <= lineNext;
            serOut      <= serNext;
            PB          <= pbNext;
            LB          <= lbNext;
            done        <= doneNext;
            frames_sent <= framesNext;
        end
    end

endmodule

// File: tb/tb_multibroadcaster_tx.sv
// Directed bench for multibroadcaster_tx: reset, framing, back-to-back, input hold-off,
// mid-frame abort and frame counter wrap.
module tb_multibroadcaster_tx;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_port = '0;
    logic [1:0]        in_line = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              serOut;
    logic [0:3]        PB;
    logic [1:0]        LB;
    logic              done;
    logic [7:0]        frames_sent;

    int total = 0;
    int bad = 0;
    int doneCnt = 0;
    logic [7:0] expFrames = '0;

    multibroadcaster_tx #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_port(in_port), .in_line(in_line), .in_data(in_data),
        .serOut(serOut), .PB(PB), .LB(LB), .done(done), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) doneCnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sends one frame and checks every cycle from accept through the return to IDLE.
    task automatic send_frame(input logic [1:0] p, input logic [1:0] l, input logic [7:0] d,
                              input bit hold, output longint acceptT, output logic [12:0] serSeq);
        logic [3:0] a;
        logic       es, ed, er;
        logic [0:3] epb;
        logic [1:0] elb;
        int         waits;
        a = {p, l};
        serSeq = '0;
        in_port = p; in_line = l; in_data = d; in_valid = 1'b1;
        waits = 0;
        while (in_ready !== 1'b1 && waits < 50) begin
            tick();
            waits++;
        end
        total++;
        if (waits >= 50) begin
            bad++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        acceptT = $time;
        #1;
        in_valid = hold;
        in_port = ~p; in_line = ~l; in_data = ~d;
        for (int o = 0; o <= 14; o++) begin
            es = 1'b1; ed = 1'b0; epb = 4'b0000; elb = 2'b00; er = (o == 14);
            if (o == 0) es = 1'b0;
            else if (o <= 4) es = a[4-o];
            else if (o <= 12) begin
                es = d[12-o]; epb = 4'b1000 >> p; elb = 2'd3 - l;
            end
            if (o == 13) begin
                ed = 1'b1;
                expFrames = expFrames + 8'd1;
            end
            if (o <= 12) serSeq = {serSeq[11:0], serOut};
            total += 6;
            if (serOut !== es) begin bad++; $display("FAIL serOut off=%0d: got %b want %b", o, serOut, es); end
            if (PB !== epb) begin bad++; $display("FAIL PB off=%0d: got %b want %b", o, PB, epb); end
            if (LB !== elb) begin bad++; $display("FAIL LB off=%0d: got %b want %b", o, LB, elb); end
            if (done !== ed) begin bad++; $display("FAIL done off=%0d: got %b want %b", o, done, ed); end
            if (in_ready !== er) begin bad++; $display("FAIL in_ready off=%0d: got %b want %b", o, in_ready, er); end
            if (frames_sent !== expFrames) begin bad++; $display("FAIL frames off=%0d: got %0d want %0d", o, frames_sent, expFrames); end
            if (o < 14) tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) tick();
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL ready_in_reset: got %b want 0", in_ready); end
        rst = 1'b1;
        repeat (5) tick();
        expFrames = '0;
        total += 6;
        if (serOut !== 1'b1) begin bad++; $display("FAIL rst_serOut: got %b want 1", serOut); end
        if (PB !== 4'b0000) begin bad++; $display("FAIL rst_PB: got %b want 0000", PB); end
        if (LB !== 2'b00) begin bad++; $display("FAIL rst_LB: got %b want 00", LB); end
        if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        if (frames_sent !== 8'd0) begin bad++; $display("FAIL rst_frames: got %0d want 0", frames_sent); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_abort;
        int d0;
        d0 = doneCnt;
        in_port = 2'd1; in_line = 2'd2; in_data = 8'h3C; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) tick();
        // third payload bit of 0x3C is bit 5 = 1, port 1 enabled
        total += 2;
        if (serOut !== 1'b1) begin bad++; $display("FAIL abort_bit3: got %b want 1", serOut); end
        if (PB !== 4'b0100) begin bad++; $display("FAIL abort_PB_pre: got %b want 0100", PB); end
        rst = 1'b0;
        tick();
        total += 6;
        if (serOut !== 1'b1) begin bad++; $display("FAIL abort_serOut: got %b want 1", serOut); end
        if (PB !== 4'b0000) begin bad++; $display("FAIL abort_PB: got %b want 0000", PB); end
        if (LB !== 2'b00) begin bad++; $display("FAIL abort_LB: got %b want 00", LB); end
        if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
        if (frames_sent !== 8'd0) begin bad++; $display("FAIL abort_frames: got %0d want 0", frames_sent); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", in_ready); end
        tick();
        rst = 1'b1;
        repeat (20) tick();
        total += 3;
        if (doneCnt != d0) begin bad++; $display("FAIL abort_nodone: got %0d pulses want 0", doneCnt - d0); end
        if (frames_sent !== 8'd0) begin bad++; $display("FAIL abort_frames_after: got %0d want 0", frames_sent); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready_after: got %b want 1", in_ready); end
        expFrames = '0;
    endtask

    task automatic test_basic;
        longint t;
        logic [12:0] seq;
        int d0;
        d0 = doneCnt;
        send_frame(2'd2, 2'd1, 8'hA5, 1'b0, t, seq);
        tick();
        total += 3;
        if (seq !== 13'b0_1001_10100101) begin bad++; $display("FAIL basic_seq: got %b want 0100110100101", seq); end
        if (frames_sent !== 8'd1) begin bad++; $display("FAIL basic_frames: got %0d want 1", frames_sent); end
        if (doneCnt - d0 != 1) begin bad++; $display("FAIL basic_donecnt: got %0d want 1", doneCnt - d0); end
    endtask

    task automatic test_back_to_back;
        longint t1, t2;
        logic [12:0] seq;
        send_frame(2'd0, 2'd3, 8'hFF, 1'b1, t1, seq);
        send_frame(2'd3, 2'd0, 8'h00, 1'b0, t2, seq);
        total++;
        if ((t2 - t1) / 10 != 15) begin bad++; $display("FAIL b2b_gap: got %0d cycles want 15", (t2 - t1) / 10); end
        send_frame(2'd1, 2'd2, 8'h5A, 1'b0, t1, seq);
        total++;
        if (seq !== 13'b0_0110_01011010) begin bad++; $display("FAIL mixed_seq: got %b want 0011001011010", seq); end
    endtask

    task automatic test_wrap;
        int d0, waits;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        expFrames = '0;
        d0 = doneCnt;
        for (int i = 0; i < 256; i++) begin
            in_port = 2'(i); in_line = 2'(i >> 2); in_data = 8'(i); in_valid = 1'b1;
            waits = 0;
            while (in_ready !== 1'b1 && waits < 40) begin tick(); waits++; end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            while (done !== 1'b1 && waits < 80) begin tick(); waits++; end
            if (waits >= 80) begin
                total++; bad++;
                $display("FAIL wrap_timeout: frame %0d no done", i);
            end
            if (i == 254) begin
                total++;
                if (frames_sent !== 8'd255) begin bad++; $display("FAIL wrap_255: got %0d want 255", frames_sent); end
            end
            tick();
        end
        tick();
        total += 2;
        if (frames_sent !== 8'd0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", frames_sent); end
        if (doneCnt - d0 != 256) begin bad++; $display("FAIL wrap_donecnt: got %0d want 256", doneCnt - d0); end
    endtask

    initial begin
        test_reset();
        test_abort();
        test_basic();
        test_back_to_back();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multibroadcaster_tx.md
MULTIBROADCASTER_TX -- requirements
Module: multibroadcaster_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (0 = reset), sampled on rising edge of clk.
REQ-004 in_valid  input  1  request to send one frame.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_port  input  2  destination port index 0..3.
REQ-007 in_line  input  2  destination line index 0..3 within the port.
REQ-008 in_data  input  DATA_W  payload, transmitted MSB first.
REQ-009 serOut  output  1  serial stream; idle level 1.
REQ-010 PB  output  4 (index 0:3)  one-hot port enable for the downstream broadcaster.
REQ-011 LB  output  2  line-select code for the downstream broadcaster.
REQ-012 done  output  1  one-cycle pulse after the last payload bit.
REQ-013 frames_sent  output  8  count of completed frames.

Function
REQ-014 The block SHALL be a Moore FSM with states IDLE, START, ADDR, DATA, DONE; all outputs except in_ready SHALL be registered.
REQ-015 in_ready SHALL be 1 exactly when state is IDLE and rst is 1.
REQ-016 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_port, in_line and in_data SHALL be captured on that edge, and later input changes SHALL NOT affect the frame.
REQ-017 On acceptance, the FSM SHALL enter START for 1 cycle: serOut=0, PB=0000.
REQ-018 ADDR SHALL last 4 cycles, driving serOut = port[1], port[0], line[1], line[0] in that order, with PB=0000.
REQ-019 DATA SHALL last DATA_W cycles, driving serOut = data[DATA_W-1] down to data[0], one bit per cycle.
REQ-020 During DATA, PB[i] SHALL be 1 only for i = captured port.
REQ-021 During DATA, LB SHALL equal 3 - captured line (line 0 -> 11, 1 -> 10, 2 -> 01, 3 -> 00).
REQ-022 Outside DATA, PB SHALL be 0000 and LB SHALL be 00.
REQ-023 DONE SHALL last 1 cycle: done=1, serOut=1, and frames_sent incremented by 1 modulo 256 (255 -> 0).
REQ-024 After DONE the FSM SHALL return to IDLE; done SHALL be 0 in every other state.
REQ-025 Frame timing: accept edge to first DONE cycle SHALL be 5 + DATA_W cycles; the next accept SHALL be possible no earlier than 7 + DATA_W cycles after the previous accept.
REQ-026 In IDLE, serOut SHALL be 1.
REQ-027 in_valid while in_ready=0 SHALL be ignored (not queued); the requester SHALL hold in_valid until accepted.
REQ-028 A bit/phase counter SHALL size to cover max(4, DATA_W) and SHALL reset to 0 on every phase entry.

Reset
REQ-029 When rst=0 at a rising edge, the block SHALL set state=IDLE, serOut=1, PB=0000, LB=00, done=0, frames_sent=0, and clear captured registers, regardless of the current state.
REQ-030 Reset mid-frame SHALL abort the frame with no done pulse and no frames_sent increment.
REQ-031 in_ready SHALL first be 1 in the cycle after the first edge with rst=1.

Verification
REQ-032 Reset, then idle 5 cycles -> serOut=1, PB=0000, LB=00, done=0, frames_sent=0, in_ready=1.
REQ-033 DATA_W=8, accept port=2, line=1, data=0xA5 -> serOut sequence 0,1,0,0,1 then 1,0,1,0,0,1,0,1; PB=0010 and LB=10 only during the 8 data cycles; done on cycle 13 after accept; frames_sent=1.
REQ-034 Back-to-back: hold in_valid high for two frames (port 0/line 3/0xFF, then port 3/line 0/0x00) -> second accept exactly 15 cycles after the first; PB=1000/LB=00 for frame 1, then PB=0001/LB=11 for frame 2; in_ready=0 throughout each frame.
REQ-035 Change in_data/in_port after acceptance -> transmitted frame unchanged.
REQ-036 Assert rst=0 during the 3rd data bit -> next cycle is IDLE values, no done pulse, frames_sent unchanged (0).
REQ-037 Send 256 frames -> frames_sent wraps to 0; done pulses exactly 256 times.
